// File: rtl/knight_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knight_link_pkg
// Brief    : Shared types and response codes for the knight command link.
// Revision : 1.0 - initial release
// ============================================================================
package knight_link_pkg;

  typedef enum logic [0:0] {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } byte_state_t;

  // Bit phase of a serial frame, shared by the RX and TX paths.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } bit_phase_t;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

endpackage
`default_nettype wire

// File: rtl/knight_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : knight_uart_tx
// Brief    : 8N1 serializer for response bytes; requests while busy are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module knight_uart_tx
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp,
  input  logic       send_resp,
  output logic       TX,
  output logic       tx_busy,
  output logic       resp_sent
);

  localparam int unsigned     c_bw        = $clog2(BAUD_DIV);
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(BAUD_DIV - 1);

  bit_phase_t      phase_q, phase_d;
  logic [7:0]      shift_q, shift_d;
  logic [c_bw-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;
  logic            w_baud_end;

  assign w_baud_end = (baud_q == c_baud_last);

  always_comb begin
    phase_d = phase_q;
    shift_d = shift_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    sent_d  = 1'b0;
    case (phase_q)
      IDLE: begin
        baud_d = '0;
        if (send_resp) begin
          shift_d = resp;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          phase_d = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          phase_d = DATA;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            phase_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        // Dropping busy with the done pulse lets a request in this cycle start the next frame.
        if (w_baud_end) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          sent_d  = 1'b1;
          phase_d = IDLE;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= IDLE;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = busy_q;
  assign resp_sent = sent_q;

endmodule
`default_nettype wire

// File: rtl/knight_cmd_link.sv
`default_nettype none
// ============================================================================
// Module   : knight_cmd_link
// Brief    : Knight-side UART command link: 2-byte command RX, response TX.
//            Optional macro CMD_TIMEOUT_EN: abandon a lone high byte after TIMEOUT clocks.
// Revision : 1.0 - initial release
// ============================================================================
module knight_cmd_link
  import knight_link_pkg::*;
#(
  parameter int BAUD_DIV = 5208,
  parameter int TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int unsigned     c_bw        = $clog2(BAUD_DIV);
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(BAUD_DIV - 1);
  localparam logic [c_bw-1:0] c_half_last = c_bw'(BAUD_DIV / 2 - 1);

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  bit_phase_t      rx_phase_q, rx_phase_d;
  logic [c_bw-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            frm_err_q, frm_err_d;
  logic            w_stop_smp;
  logic            w_byte_vld;
  logic            w_timeout;

  byte_state_t     state_q, state_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_phase_d = rx_phase_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    w_stop_smp = 1'b0;
    case (rx_phase_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_phase_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (rx_cnt_q == c_half_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_phase_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q == c_baud_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_phase_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      STOP: begin
        if (rx_cnt_q == c_baud_last) begin
          rx_cnt_d   = '0;
          w_stop_smp = 1'b1;
          rx_phase_d = IDLE;
        end
      end
      default: rx_phase_d = IDLE;
    endcase
  end

  assign w_byte_vld = w_stop_smp & rx_s2_q;
  assign frm_err_d  = w_stop_smp & ~rx_s2_q;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned       c_tw       = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0]   c_to_limit = c_tw'(TIMEOUT);

  logic [c_tw-1:0] to_cnt_q, to_cnt_d;

  assign w_timeout = (state_q == WAIT_LO) && (to_cnt_q == c_to_limit);

  always_comb begin
    to_cnt_d = '0;
    if (state_q == WAIT_LO && !w_byte_vld && !w_timeout) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign w_timeout = 1'b0;
  if (TIMEOUT > 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (w_byte_vld) begin
      if (state_q == WAIT_HI) begin
        hi_byte_d = rx_shift_q;
        cmd_rdy_d = 1'b0;
        state_d   = WAIT_LO;
      end else begin
        // Applied after the clear so a same-cycle clr_cmd_rdy loses.
        cmd_d     = {hi_byte_q, rx_shift_q};
        cmd_rdy_d = 1'b1;
        state_d   = WAIT_HI;
      end
    end else if (w_timeout) begin
      hi_byte_d = '0;
      state_d   = WAIT_HI;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_phase_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      frm_err_q  <= 1'b0;
      state_q    <= WAIT_HI;
      hi_byte_q  <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      rx_phase_q <= rx_phase_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      frm_err_q  <= frm_err_d;
      state_q    <= state_d;
      hi_byte_q  <= hi_byte_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

  knight_uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .resp      (resp),
    .send_resp (send_resp),
    .TX        (TX),
    .tx_busy   (tx_busy),
    .resp_sent (resp_sent)
  );

endmodule
`default_nettype wire

// File: doc/knight_cmd_link.md
# knight_cmd_link

Knight-side end of the remote command link: deserializes the 8N1 UART stream sent by the remote commander into 16-bit commands, and serializes the 8-bit response bytes (positive ack, move-done) back to it. Sits between the KnightsTour RX/TX pins and the command processor. A command arrives as two bytes, high byte first. The link hands the command over through a cmd_rdy/clr_cmd_rdy handshake and accepts responses via send_resp.

## Interface
- BAUD_DIV, 5208: clocks per UART bit (50 MHz / 9600 baud); must be ≥ 8.
- TIMEOUT, 1000000: max clocks between high and low byte (used only with CMD_TIMEOUT_EN).
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- RX  in  1  serial input from remote, idle high, asynchronous.
- TX  out  1  serial output to remote, idle high.
- cmd  out  16  last assembled command {high byte, low byte}.
- cmd_rdy  out  1  level; a new command is waiting in cmd.
- clr_cmd_rdy  in  1  consumer has taken cmd.
- resp  in  8  response byte to send.
- send_resp  in  1  one-cycle request to transmit resp.
- tx_busy  out  1  transmitter is shifting a frame.
- resp_sent  out  1  one-cycle pulse when the response stop bit completes.
- frm_err  out  1  one-cycle pulse when a received byte had stop bit = 0.

## Operation
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_busy=0, resp_sent=0, frm_err=0, byte FSM in WAIT_HI.
- RX path:
  - RX passes through a 2-flop synchronizer, preset to 1 on reset.
  - A falling edge of the synchronized RX starts a frame.
  - Start bit is resampled at BAUD_DIV/2. If it reads 1, the frame is a glitch and is dropped.
  - Data bits, LSB first, are sampled every BAUD_DIV clocks after that, followed by the stop bit.
- Stop = 0: byte discarded, frm_err pulses, byte FSM is unchanged.
- Byte FSM:
  - WAIT_HI, on valid byte: latch hi_byte, clear cmd_rdy, go to WAIT_LO.
  - WAIT_LO, on valid byte: cmd <= {hi_byte, byte}, cmd_rdy <= 1, go to WAIT_HI.
- cmd_rdy:
  - Cleared by clr_cmd_rdy.
  - If clr_cmd_rdy and assembly occur in the same cycle, set wins.
  - cmd changes only on assembly.
- TX path:
  - send_resp is accepted only when tx_busy=0. Requests made while busy are ignored, not queued.
  - On acceptance, resp is latched and tx_busy rises.
  - Frame sent: start bit 0, resp[0..7], stop bit 1, each BAUD_DIV clocks.
  - After the stop bit: tx_busy falls and resp_sent pulses in the same cycle.
- RX and TX are fully independent; full duplex is allowed.
- Reset mid-frame: both paths abort immediately and TX returns to 1. A partial RX byte and a stored hi_byte are lost.

## Timing
- A valid byte completes BAUD_DIV/2 + 9·BAUD_DIV clocks after the start edge is seen on the synchronized RX.
- RX pin to synchronized RX: 2 clocks.
- cmd and cmd_rdy update 1 clock after the low byte's stop-bit sample.
- TX falls 1 clock after send_resp is accepted.
- resp_sent occurs 10·BAUD_DIV clocks after TX falls.
- A new send_resp in the resp_sent cycle is accepted; back-to-back frames are allowed.

## Configuration
- CMD_TIMEOUT_EN defined:
  - A counter runs while the FSM is in WAIT_LO.
  - When it reaches TIMEOUT, the FSM returns to WAIT_HI and discards hi_byte. cmd_rdy is unaffected.
  - Any valid byte restarts the count.
- CMD_TIMEOUT_EN undefined:
  - No counter is present; the FSM waits in WAIT_LO indefinitely.
  - The TIMEOUT parameter is ignored.

## Structure
- Shared package knight_link_pkg:
  - byte_state_t enum (WAIT_HI, WAIT_LO).
  - Bit-phase enum (IDLE, START, DATA, STOP) used by both serial paths.
  - Response constants POS_ACK=8'hA5 and NEG_ACK=8'hEE.
- One sub-module, knight_uart_tx: shift register, baud counter, bit counter. Interface: resp/send_resp in; TX/tx_busy/resp_sent out.
- The RX deserializer and byte FSM stay in the top module.

## Test plan
All scenarios use BAUD_DIV=16.
- Command assembly: send bytes 8'h4B then 8'hF1 → cmd=16'h4BF1 and cmd_rdy=1, exactly 1 clock after the second stop sample; cmd_rdy stays high until clr_cmd_rdy is pulsed.
- Set beats clear: assert clr_cmd_rdy in the assembly cycle of 16'h2002 → cmd_rdy=1, cmd=16'h2002.
- Framing error: send 8'h4B with stop=0 → frm_err pulses once. Then 8'h4B, 8'hF1 → cmd=16'h4BF1, so the bad byte consumed no FSM slot.
- Glitch rejection: drive a 3-clock low pulse on RX → no frm_err, no state change, cmd_rdy stays 0.
- Response transmit:
  - send_resp with resp=8'hA5 → TX shows 0,1,0,1,0,0,1,0,1,1 at 16-clock spacing.
  - resp_sent occurs at 160 clocks after TX falls.
  - A second send_resp at cycle 50 is ignored.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT=1000): send 8'h4B, idle 1200 clocks, then send 8'h20, 8'h02 → cmd=16'h2002.
- Reset mid-frame: assert rst 40 clocks into a TX frame → TX=1, tx_busy=0 immediately, with no resp_sent.
